counter_sequencer: RTL
======================

# counter_sequencer

Programmable sequencer for the 8-bit up/down counter. On a start request it captures a configuration and drives the counter's `load`, `load_data`, `enb` and `mode` pins through a load phase followed by repeated count-up and count-down phases. It tracks the value the counter should reach, checks the counter's output at completion and flags any mismatch. It sits between the register/config logic and the counter instance, and is the only driver of the counter's control pins.

## Interface
- `WIDTH`, 8: counter data width.
- `RPT_W`, 4: width of the repeat field.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `abort`  in  1  cancel the sequence in progress.
- `cfg_load`  in  WIDTH  value loaded into the counter.
- `cfg_up`  in  WIDTH  count-up cycles per repeat.
- `cfg_down`  in  WIDTH  count-down cycles per repeat.
- `cfg_repeat`  in  RPT_W  number of up/down repeats; 0 is treated as 1.
- `cnt_value`  in  WIDTH  counter `out`.
- `cnt_load`  out  1  to counter `load`.
- `cnt_load_data`  out  WIDTH  to counter `load_data`.
- `cnt_enb`  out  1  to counter `enb`.
- `cnt_mode`  out  1  to counter `mode` (1 = up, 0 = down).
- `busy`  out  1  high from LOAD through DONE inclusive.
- `done`  out  1  one-cycle pulse in DONE.
- `err`  out  1  sticky mismatch flag; cleared on the next accepted start.

## Operation
- States:
  - IDLE: `start`=1 latches all `cfg_*` and clears `err`; goes to LOAD.
  - LOAD: one cycle; `cnt_load`=1 and `cnt_load_data`=latched load; `exp`←load. Goes to UP if up≠0, else DOWN if down≠0, else DONE.
  - UP: `cnt_enb`=1 and `cnt_mode`=1 for exactly `up` cycles; `exp`+=1 each cycle. Then goes to DOWN if down≠0, else REPEAT-check.
  - DOWN: `cnt_enb`=1 and `cnt_mode`=0 for exactly `down` cycles; `exp`-=1 each cycle. Then REPEAT-check.
  - REPEAT-check: combinational, not a state. If repeats remain, go to UP (or DOWN if up=0); there is no reload. Otherwise go to DONE.
  - DONE: one cycle; `done`=1; `err` set if `cnt_value`≠`exp`; then IDLE.
- `cnt_load` and `cnt_enb` are never high in the same cycle.
- `cnt_load_data` holds the latched load value whenever the block is not in IDLE. It is 0 in IDLE.
- `exp` and all count arithmetic are modulo 2^WIDTH; wrap-around is legal and is not an error.
- The phase-length counter reloads on each phase entry, so phases of 255 cycles are legal.
- `abort`=1 in any state other than IDLE: the next state is IDLE, all counter controls deassert, `done` is not pulsed and `err` is unchanged. `abort` in IDLE is ignored.
- `start` while busy is ignored; configuration changes while busy are ignored.
- Reset value of every output is 0. `rst` takes priority over `abort` and `start`, and forces IDLE from any state.

## Timing
- `start` is sampled at edge k; LOAD occupies cycle k+1.
- Busy duration is 2 + R·(U+D) cycles, where R = max(cfg_repeat, 1).
- The counter updates at the edge that ends each enb cycle, so `cnt_value` is final during the DONE cycle. The comparison is made in that cycle and `err` is registered at the end of DONE.
- `done` and the `busy` falling edge: `busy` is 0 in the cycle after DONE, and `start` is accepted in that same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `counter_seq_pkg`: state enum (IDLE, LOAD, UP, DOWN, DONE) and default `WIDTH`/`RPT_W` constants.
- Sub-module `seq_phase_timer`: a loadable down-counter that generates the phase-length terminal count. It is reused for the UP and DOWN phases.
- The top-level bench instantiates `counter_sequencer` together with the counter.

## Test plan
- Load 0xAA, up 5, down 5, repeat 1 → 12 busy cycles, `done` pulses once, `cnt_value`=0xAA, `err`=0.
- Load 0xFE, up 4, down 0 → counter wraps to 0x02, `err`=0, 6 busy cycles.
- Load 0x10, up 3, down 1, repeat 3 → 14 busy cycles, final value 0x16, and no `cnt_load` pulse after the LOAD cycle.
- Up 0, down 0 → LOAD then DONE, 2 busy cycles, and `cnt_enb` never asserts.
- Assert `abort` at the 3rd UP cycle → IDLE next cycle, no `done` pulse; a `start` in the following cycle is accepted.
- Bench forces `cnt_value` to be off by one during DONE → `err`=1, held until the next start.
- Pull `rst` low during DOWN → all outputs 0 on the next edge, state IDLE.

Source files
------------

// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_pkg
// Brief    : Shared state encoding and default widths for the counter sequencer.
// Revision : 1.0
// ============================================================================
package counter_seq_pkg;

    localparam int c_WIDTH = 8;
    localparam int c_RPT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_phase_timer
// Brief    : Loadable down-counter; tc marks the last cycle of a phase.
// Revision : 1.0
// ============================================================================
module seq_phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;

    // Loaded with (length - 1) on phase entry, so a full 255-cycle phase fits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer
// Brief    : Drives an up/down counter through load/up/down phases, checks result.
// Revision : 1.0
// ============================================================================
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int RPT_W = c_RPT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_load,
    input  logic [WIDTH-1:0] cfg_up,
    input  logic [WIDTH-1:0] cfg_down,
    input  logic [RPT_W-1:0] cfg_repeat,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_data,
    output logic             cnt_enb,
    output logic             cnt_mode,
    output logic             busy,
    output logic             done,
    output logic             err
);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;

    logic [WIDTH-1:0] r_cfg_load;
    logic [WIDTH-1:0] r_cfg_up;
    logic [WIDTH-1:0] r_cfg_down;
    logic [RPT_W-1:0] r_rpt;
    logic [WIDTH-1:0] r_exp;

    logic             r_cnt_load;
    logic [WIDTH-1:0] r_cnt_load_data;
    logic             r_cnt_enb;
    logic             r_cnt_mode;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_tmr_load;
    logic [WIDTH-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tmr_tc;
    logic             w_rpt_dec;
    logic             w_more;
    logic             w_has_up;
    logic             w_has_down;
    logic             w_accept;

    assign w_has_up   = (r_cfg_up != '0);
    assign w_has_down = (r_cfg_down != '0);
    assign w_more     = (r_rpt > RPT_W'(1));
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_tmr_en   = (r_state == ST_UP) || (r_state == ST_DOWN);

    seq_phase_timer #(
        .WIDTH (WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .tc       (w_tmr_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_rpt_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_has_up) begin
                    w_state_nxt = ST_UP;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = r_cfg_up - WIDTH'(1);
                end else if (w_has_down) begin
                    w_state_nxt = ST_DOWN;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = r_cfg_down - WIDTH'(1);
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_UP, ST_DOWN: begin
                if (w_tmr_tc) begin
                    if ((r_state == ST_UP) && w_has_down) begin
                        w_state_nxt = ST_DOWN;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = r_cfg_down - WIDTH'(1);
                    end else if (w_more) begin
                        // Next repeat restarts counting from the current value; no reload.
                        w_rpt_dec   = 1'b1;
                        w_tmr_load  = 1'b1;
                        w_state_nxt = w_has_up ? ST_UP : ST_DOWN;
                        w_tmr_val   = w_has_up ? (r_cfg_up - WIDTH'(1))
                                               : (r_cfg_down - WIDTH'(1));
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_tmr_load  = 1'b0;
            w_rpt_dec   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_cfg_load      <= '0;
            r_cfg_up        <= '0;
            r_cfg_down      <= '0;
            r_rpt           <= '0;
            r_exp           <= '0;
            r_cnt_load      <= 1'b0;
            r_cnt_load_data <= '0;
            r_cnt_enb       <= 1'b0;
            r_cnt_mode      <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_cfg_load <= cfg_load;
                r_cfg_up   <= cfg_up;
                r_cfg_down <= cfg_down;
                r_rpt      <= (cfg_repeat == '0) ? RPT_W'(1) : cfg_repeat;
                r_err      <= 1'b0;
            end else if (w_rpt_dec) begin
                r_rpt <= r_rpt - RPT_W'(1);
            end

            case (r_state)
                ST_LOAD: r_exp <= r_cfg_load;
                ST_UP:   r_exp <= r_exp + WIDTH'(1);
                ST_DOWN: r_exp <= r_exp - WIDTH'(1);
                default: r_exp <= r_exp;
            endcase

            if ((r_state == ST_DONE) && !abort && (cnt_value != r_exp)) begin
                r_err <= 1'b1;
            end

            // Outputs are registered from the next state to keep them glitch-free.
            r_cnt_load      <= (w_state_nxt == ST_LOAD);
            r_cnt_load_data <= (w_state_nxt == ST_IDLE) ? '0 :
                               ((r_state == ST_IDLE) ? cfg_load : r_cfg_load);
            r_cnt_enb       <= (w_state_nxt == ST_UP) || (w_state_nxt == ST_DOWN);
            r_cnt_mode      <= (w_state_nxt == ST_UP);
            r_busy          <= (w_state_nxt != ST_IDLE);
            r_done          <= (w_state_nxt == ST_DONE);
        end
    end

    assign cnt_load      = r_cnt_load;
    assign cnt_load_data = r_cnt_load_data;
    assign cnt_enb       = r_cnt_enb;
    assign cnt_mode      = r_cnt_mode;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule
`default_nettype wire
